// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmit and keyboard receive paths.
package ps2_pkg;

  // Host transmit sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StXfer,
    StAck,
    StWaitIdle,
    StFin
  } ps2_state_e;

  // Common keyboard command bytes and the device acknowledge response.
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // Start, 8 data, parity, stop.
  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_BIT_CNT_W  = 4;

  // Bits shifted out after the start bit: {stop, odd parity, data}.
  function automatic logic [9:0] ps2_tx_shift(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning: 2-flop synchronizers, optional clock glitch filter and
// registered falling-edge detect on the clock line. Shared with the receive path.
// Build option: PS2_TX_GLITCH_FILTER_EN enables the FILTER_LEN-sample clock filter.
module ps2_line_sync
`ifdef PS2_TX_GLITCH_FILTER_EN
#(
  parameter int unsigned FILTER_LEN = 8
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fe
);

  logic [1:0] clk_meta_q;
  logic [1:0] data_meta_q;
  logic       clk_prev_q;
  logic       clk_fe_q;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q  <= 2'b11;
      data_meta_q <= 2'b11;
    end else begin
      clk_meta_q  <= {clk_meta_q[0], clk_pin};
      data_meta_q <= {data_meta_q[0], data_pin};
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CntW-1:0] filt_cnt_q;
  logic            clk_filt_q;

  // Filtered clock follows the synchronized clock only after FILTER_LEN matching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_q <= '0;
      clk_filt_q <= 1'b1;
    end else if (clk_meta_q[1] == clk_filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == CntW'(FILTER_LEN - 1)) begin
      filt_cnt_q <= '0;
      clk_filt_q <= clk_meta_q[1];
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign clk_sync = clk_filt_q;
`else
  assign clk_sync = clk_meta_q[1];
`endif

  assign data_sync = data_meta_q[1];

  // Falling edge registered from previous/current clock level: one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_prev_q <= 1'b1;
      clk_fe_q   <= 1'b0;
    end else begin
      clk_prev_q <= clk_sync;
      clk_fe_q   <= clk_prev_q & ~clk_sync;
    end
  end

  assign clk_fe = clk_fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, issues request-to-send,
// shifts one byte out on device-generated clock edges and samples the device ack.
// Pads are open-collector: line = oe ? 1'b0 : 1'bz at the chip top.
// Build option: PS2_TX_GLITCH_FILTER_EN filters the incoming clock (adds FILTER_LEN).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
`ifdef PS2_TX_GLITCH_FILTER_EN
  ,
  parameter int unsigned FILTER_LEN     = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam logic [PS2_BIT_CNT_W-1:0] StopCnt = PS2_BIT_CNT_W'(PS2_FRAME_BITS - 1);

  ps2_state_e state_q, state_d;

  logic [9:0]               shift_q, shift_d;
  logic [PS2_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [31:0]              cnt_q, cnt_d;
  logic                     clk_oe_q, clk_oe_d;
  logic                     data_oe_q, data_oe_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     ack_err_q, ack_err_d;
  logic [PS2_FRAME_BITS-1:0] frame_d;

  logic clk_sync;
  logic data_sync;
  logic clk_fe;

  ps2_line_sync
`ifdef PS2_TX_GLITCH_FILTER_EN
  #(
    .FILTER_LEN(FILTER_LEN)
  )
`endif
  u_line_sync (
    .clk      (clk),
    .reset    (reset),
    .clk_pin  (ps2_clk_in),
    .data_pin (ps2_data_in),
    .clk_sync (clk_sync),
    .data_sync(data_sync),
    .clk_fe   (clk_fe)
  );

  // Next-state logic; line enables are decoded from the next state so the pads are registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    ack_err_d = ack_err_q;

    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          shift_d   = ps2_tx_shift(tx_data);
          bit_cnt_d = '0;
          cnt_d     = '0;
          ack_err_d = 1'b0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StRts;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRts: begin
        // Clock is released next; the timeout window starts from here.
        cnt_d   = '0;
        state_d = StXfer;
      end
      StXfer, StAck, StWaitIdle: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          ack_err_d = 1'b1;
          state_d   = StFin;
        end else if (state_q == StXfer) begin
          if (clk_fe) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_d == StopCnt) begin
              state_d = StAck;
            end
          end
        end else if (state_q == StAck) begin
          if (clk_fe) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            ack_err_d = data_sync;
            state_d   = StWaitIdle;
          end
        end else if (clk_sync && data_sync) begin
          // Late clock edges here are ignored; only bus-idle matters.
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Bit 0 of the frame is the start bit, driven low from RTS onward.
    frame_d   = {shift_d, 1'b0};
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    unique case (state_d)
      StInhibit: clk_oe_d = 1'b1;
      StRts: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
      end
      StXfer:  data_oe_d = ~frame_d[bit_cnt_d];
      default: ;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StFin);
  end

  // State and output registers; reset releases both lines on the first edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a keyboard device model drives the clock and acks,
// and each received frame is compared with one built from the command byte.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int Inh  = 300;
  localparam int Tmo  = 2000;
  localparam int Half = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err;

  int n_checks = 0;
  int n_fail = 0;

  int         inh_cnt = 0, rts_cnt = 0, busy_gap = 0, done_cnt = 0, done_base = 0;
  bit         mon_en = 1'b0;
  logic       done_ack = 1'b0;
  logic [1:0] done_lines = 2'b00;

  always #5 clk = ~clk;

  // Wired-AND open-collector bus shared by host and device.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inh),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err)
  );

  // Observe on the falling system clock edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
      if (ps2_clk_oe && ps2_data_oe) rts_cnt++;
      if (!busy && done_cnt == done_base) busy_gap++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_ack   = ack_err;
      done_lines = {ps2_clk_oe, ps2_data_oe};
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got time limit reached, expected summary before it");
    $fatal(1);
  end

  // Expected line levels in send order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Device side of one host-to-device frame.
  task automatic dev_serve(input bit nack, input int stop_fe, input int poke_fe,
                           input int glitch_fe, output logic [10:0] seen, output bit started);
    seen = '0;
    started = 1'b0;
    for (int i = 0; i < Inh + 50; i++) begin
      if (ps2_clk_in && !ps2_data_in) begin
        started = 1'b1;
        break;
      end
      tick();
    end
    if (!started) return;
    repeat (Half) tick();
    seen[0] = ps2_data_in;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_data_low = ~nack;
        repeat (Half) tick();
      end
      dev_clk_low = 1'b1;
      repeat (Half) tick();
      if (k == stop_fe) return;
      if (k == poke_fe) begin
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
      end
      dev_clk_low = 1'b0;
      if (k <= 10) seen[k] = ps2_data_in;
      if (k == glitch_fe) begin
        repeat (5) tick();
        dev_clk_low = 1'b1;
        repeat (3) tick();
        dev_clk_low = 1'b0;
        repeat (Half - 8) tick();
      end else begin
        repeat (Half) tick();
      end
    end
    dev_data_low = 1'b0;
  endtask

  // Full transaction: start request, device service, bounded wait for done.
  task automatic run_txn(input logic [7:0] b, input bit nack, input int poke_fe,
                         input int glitch_fe, output logic [10:0] seen, output bit fin);
    bit started;
    int base;
    inh_cnt   = 0;
    rts_cnt   = 0;
    busy_gap  = 0;
    base      = done_cnt;
    done_base = done_cnt;
    tx_data   = b;
    tx_start  = 1'b1;
    tick();
    tx_start  = 1'b0;
    tx_data   = 8'($urandom);
    mon_en    = 1'b1;
    dev_serve(nack, 0, poke_fe, glitch_fe, seen, started);
    fin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != base) begin
        fin = started;
        break;
      end
      tick();
    end
    mon_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tx_start = 1'b1;
    tx_data  = PS2_CMD_RESET;
    repeat (3) tick();
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, ack_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 00000",
               {ps2_clk_oe, ps2_data_oe, busy, done, ack_err});
    end
    reset    = 1'b0;
    tx_start = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_set_leds();
    logic [10:0] seen;
    bit fin;
    run_txn(PS2_CMD_SET_LEDS, 1'b0, 0, 0, seen, fin);
    n_checks++;
    if (fin !== 1'b1) begin n_fail++; $display("FAIL leds_done: got %b, expected 1", fin); end
    n_checks++;
    if (inh_cnt !== Inh) begin
      n_fail++; $display("FAIL leds_inhibit_len: got %0d, expected %0d", inh_cnt, Inh);
    end
    n_checks++;
    if (rts_cnt !== 1) begin
      n_fail++; $display("FAIL leds_rts_len: got %0d, expected 1", rts_cnt);
    end
    n_checks++;
    if (seen !== exp_frame(PS2_CMD_SET_LEDS)) begin
      n_fail++; $display("FAIL leds_frame: got %b, expected %b", seen, exp_frame(PS2_CMD_SET_LEDS));
    end
    n_checks++;
    if (done_ack !== 1'b0) begin n_fail++; $display("FAIL leds_ack: got %b, expected 0", done_ack); end
    n_checks++;
    if (busy_gap !== 0) begin
      n_fail++; $display("FAIL leds_busy: got %0d low cycles, expected 0", busy_gap);
    end
    n_checks++;
    if (done_lines !== 2'b00) begin
      n_fail++; $display("FAIL leds_lines: got %b, expected 00", done_lines);
    end
  endtask

  task automatic test_parity();
    logic [10:0] seen;
    bit fin;
    logic [7:0] b;
    logic exp_par;
    for (int i = 0; i < 2; i++) begin
      b       = 8'(i);
      exp_par = (i == 0) ? 1'b1 : 1'b0;
      run_txn(b, 1'b0, 0, 0, seen, fin);
      n_checks++;
      if (seen[9] !== exp_par) begin
        n_fail++; $display("FAIL parity_%0d: got %b, expected %b", i, seen[9], exp_par);
      end
      n_checks++;
      if ({fin, done_ack} !== 2'b10 || seen !== exp_frame(b)) begin
        n_fail++;
        $display("FAIL parity_txn_%0d: got fin/ack=%b%b frame=%b, expected 10 frame=%b",
                 i, fin, done_ack, seen, exp_frame(b));
      end
    end
  endtask

  task automatic test_nack();
    logic [10:0] seen;
    bit fin;
    run_txn(PS2_CMD_RESET, 1'b1, 0, 0, seen, fin);
    n_checks++;
    if ({fin, done_ack} !== 2'b11) begin
      n_fail++; $display("FAIL nack_ack_err: got fin/ack=%b%b, expected 11", fin, done_ack);
    end
    n_checks++;
    if ({done_lines, busy, ps2_clk_oe, ps2_data_oe} !== 5'b0) begin
      n_fail++;
      $display("FAIL nack_release: got %b, expected 00000",
               {done_lines, busy, ps2_clk_oe, ps2_data_oe});
    end
    n_checks++;
    if (ack_err !== 1'b1) begin
      n_fail++; $display("FAIL nack_hold: got ack_err=%b, expected 1", ack_err);
    end
  endtask

  task automatic test_timeout();
    bit rel;
    int cyc;
    tx_data  = PS2_CMD_ENABLE;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    rel = 1'b0;
    for (int i = 0; i < Inh + 50; i++) begin
      if (busy && !ps2_clk_oe) begin
        rel = 1'b1;
        break;
      end
      tick();
    end
    cyc = 0;
    while (rel && done !== 1'b1 && cyc < Tmo + 50) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== Tmo) begin
      n_fail++; $display("FAIL timeout_len: got %0d cycles, expected %0d", cyc, Tmo);
    end
    n_checks++;
    if ({done, ack_err, ps2_clk_oe, ps2_data_oe} !== 4'b1100) begin
      n_fail++;
      $display("FAIL timeout_done: got %b, expected 1100", {done, ack_err, ps2_clk_oe, ps2_data_oe});
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] seen;
    bit started, fin;
    tx_data  = PS2_CMD_ENABLE;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    dev_serve(1'b0, 5, 0, 0, seen, started);
    n_checks++;
    if ({started, busy} !== 2'b11) begin
      n_fail++; $display("FAIL midreset_pre: got started/busy=%b%b, expected 11", started, busy);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL midreset_release: got %b, expected 0000", {ps2_clk_oe, ps2_data_oe, busy, done});
    end
    reset       = 1'b0;
    dev_clk_low = 1'b0;
    repeat (5) tick();
    run_txn(PS2_CMD_ENABLE, 1'b0, 0, 0, seen, fin);
    n_checks++;
    if ({fin, done_ack} !== 2'b10 || seen !== exp_frame(PS2_CMD_ENABLE)) begin
      n_fail++;
      $display("FAIL midreset_retry: got fin/ack=%b%b frame=%b, expected 10 frame=%b",
               fin, done_ack, seen, exp_frame(PS2_CMD_ENABLE));
    end
  endtask

  task automatic test_start_ignored();
    logic [10:0] seen;
    bit fin;
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hAA) b = 8'h55;
    run_txn(b, 1'b0, 4, 0, seen, fin);
    n_checks++;
    if ({fin, done_ack} !== 2'b10 || seen !== exp_frame(b)) begin
      n_fail++;
      $display("FAIL ignored_start: got fin/ack=%b%b frame=%b, expected 10 frame=%b",
               fin, done_ack, seen, exp_frame(b));
    end
    repeat (5) tick();
    n_checks++;
    if ({busy, ps2_clk_oe} !== 2'b00) begin
      n_fail++; $display("FAIL ignored_no_queue: got busy/clk_oe=%b, expected 00", {busy, ps2_clk_oe});
    end
  endtask

`ifdef PS2_TX_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic [10:0] seen;
    bit fin;
    run_txn(PS2_CMD_SET_LEDS, 1'b0, 0, 3, seen, fin);
    n_checks++;
    if ({fin, done_ack} !== 2'b10 || seen !== exp_frame(PS2_CMD_SET_LEDS)) begin
      n_fail++;
      $display("FAIL glitch_reject: got fin/ack=%b%b frame=%b, expected 10 frame=%b",
               fin, done_ack, seen, exp_frame(PS2_CMD_SET_LEDS));
    end
  endtask
`endif

  task automatic test_random();
    logic [10:0] seen;
    bit fin, nack;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b    = (i == 0) ? PS2_RESP_ACK : 8'($urandom);
      nack = 1'($urandom_range(0, 1));
      run_txn(b, nack, 0, 0, seen, fin);
      n_checks++;
      if ({fin, done_ack} !== {1'b1, nack} || seen !== exp_frame(b)) begin
        n_fail++;
        $display("FAIL random_%0d: got fin/ack=%b%b frame=%b, expected 1%b frame=%b",
                 i, fin, done_ack, seen, nack, exp_frame(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_leds();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_start_ignored();
`ifdef PS2_TX_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
